// File: rtl/change_dispenser_if.sv
// change_dispenser_if
// Bundles the request and status signals between the vending-machine core
// (master) and the coin payout block (slave).
//   change_valid  : one-cycle payout request strobe (master -> slave)
//   change_amount : change to pay in zl, unsigned (master -> slave)
//   refill        : reload all coin stocks to their initial counts (master -> slave)
//   Money_out     : one-hot coin being ejected, 001=1zl 010=2zl 100=5zl (slave -> master)
//   busy          : payout in progress, through the done cycle (slave -> master)
//   done          : one-cycle end-of-transaction pulse (slave -> master)
//   short         : last payout was incomplete (slave -> master)
//   shortfall     : unpaid zl while short=1 (slave -> master)
//   stock5/2/1    : current coin counts per denomination (slave -> master)
interface change_dispenser_if;
    logic       change_valid;
    logic [7:0] change_amount;
    logic       refill;
    logic [2:0] Money_out;
    logic       busy;
    logic       done;
    logic       short;
    logic [7:0] shortfall;
    logic [7:0] stock5;
    logic [7:0] stock2;
    logic [7:0] stock1;

    modport master (
        output change_valid, change_amount, refill,
        input  Money_out, busy, done, short, shortfall, stock5, stock2, stock1
    );

    modport slave (
        input  change_valid, change_amount, refill,
        output Money_out, busy, done, short, shortfall, stock5, stock2, stock1
    );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser
// Payout side of the vending machine's coin interface. Takes a change amount
// from the core, pays it out greedily (5zl, then 2zl, then 1zl, skipping any
// denomination whose stock is empty) as one-hot pulses on Money_out, tracks
// per-denomination coin stock and reports any unpaid remainder.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : change_dispenser_if slave modport (request, coin output, status, stock)
// Parameters:
//   PULSE_CYCLES : cycles each coin code is held on Money_out (>= 1)
//   GAP_CYCLES   : idle cycles between coins (>= 1)
//   STOCKx_INIT  : coin counts loaded at reset and on refill
module change_dispenser #(
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 2,
    parameter int unsigned STOCK5_INIT  = 10,
    parameter int unsigned STOCK2_INIT  = 10,
    parameter int unsigned STOCK1_INIT  = 10
) (
    input  logic               clk,
    input  logic               reset,
    change_dispenser_if.slave  bus
);

    localparam logic [2:0] COIN_NONE = 3'b000;
    localparam logic [2:0] COIN_1    = 3'b001;
    localparam logic [2:0] COIN_2    = 3'b010;
    localparam logic [2:0] COIN_5    = 3'b100;

    localparam int unsigned CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    localparam logic [7:0] INIT5 = 8'(STOCK5_INIT);
    localparam logic [7:0] INIT2 = 8'(STOCK2_INIT);
    localparam logic [7:0] INIT1 = 8'(STOCK1_INIT);

    typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;

    // Greedy choice with fallback: largest coin that fits and is in stock.
    function automatic logic [2:0] pick_coin(input logic [7:0] rem,
                                             input logic [7:0] s5,
                                             input logic [7:0] s2,
                                             input logic [7:0] s1);
        if (rem >= 8'd5 && s5 != 8'd0)      return COIN_5;
        else if (rem >= 8'd2 && s2 != 8'd0) return COIN_2;
        else if (rem >= 8'd1 && s1 != 8'd0) return COIN_1;
        else                                return COIN_NONE;
    endfunction

    function automatic logic [7:0] coin_value(input logic [2:0] coin);
        case (coin)
            COIN_5:  return 8'd5;
            COIN_2:  return 8'd2;
            COIN_1:  return 8'd1;
            default: return 8'd0;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [7:0]       rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       money_q, money_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             short_q, short_d;
    logic [7:0]       shortfall_q, shortfall_d;
    logic [7:0]       s5_q, s5_d;
    logic [7:0]       s2_q, s2_d;
    logic [7:0]       s1_q, s1_d;
    logic [2:0]       coin;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rem_q       <= 8'd0;
            cnt_q       <= '0;
            money_q     <= COIN_NONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            shortfall_q <= 8'd0;
            s5_q        <= INIT5;
            s2_q        <= INIT2;
            s1_q        <= INIT1;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            money_q     <= money_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            short_q     <= short_d;
            shortfall_q <= shortfall_d;
            s5_q        <= s5_d;
            s2_q        <= s2_d;
            s1_q        <= s1_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        money_d     = money_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        short_d     = short_q;
        shortfall_d = shortfall_q;
        s5_d        = s5_q;
        s2_d        = s2_q;
        s1_d        = s1_q;
        coin        = pick_coin(rem_q, s5_q, s2_q, s1_q);

        case (state_q)
            IDLE: begin
                // Refill lands in the same edge as a request, so SELECT sees full stock.
                if (bus.refill) begin
                    s5_d = INIT5;
                    s2_d = INIT2;
                    s1_d = INIT1;
                end
                if (bus.change_valid) begin
                    rem_d       = bus.change_amount;
                    short_d     = 1'b0;
                    shortfall_d = 8'd0;
                    state_d     = SELECT;
                end
            end
            SELECT: begin
                // busy rises on leaving the first SELECT and stays up through DONE.
                busy_d = 1'b1;
                if (coin != COIN_NONE) begin
                    money_d = coin;
                    rem_d   = rem_q - coin_value(coin);
                    cnt_d   = '0;
                    state_d = PULSE;
                    case (coin)
                        COIN_5:  s5_d = s5_q - 8'd1;
                        COIN_2:  s2_d = s2_q - 8'd1;
                        default: s1_d = s1_q - 8'd1;
                    endcase
                end else begin
                    done_d  = 1'b1;
                    state_d = DONE;
                    if (rem_q != 8'd0) begin
                        short_d     = 1'b1;
                        shortfall_d = rem_q;
                    end
                end
            end
            PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    money_d = COIN_NONE;
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = SELECT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.Money_out = money_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.short     = short_q;
    assign bus.shortfall = shortfall_q;
    assign bus.stock5    = s5_q;
    assign bus.stock2    = s2_q;
    assign bus.stock1    = s1_q;

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Payout side of the vending machine's coin interface.
- The vending_machine core computes change and hands this block an amount in zl.
- The block drives the coin-ejector mechanism with one-hot coin pulses, using the same 3-bit encoding the core accepts on Money_in: 001 = 1zl, 010 = 2zl, 100 = 5zl.
- It tracks per-denomination coin stock and reports a shortfall when exact change cannot be paid.

Parameters:
- PULSE_CYCLES, 4: cycles Money_out is held per coin (must be ≥1).
- GAP_CYCLES, 2: idle cycles between coins (must be ≥1).
- STOCK5_INIT, 10: 5zl coins loaded at reset/refill.
- STOCK2_INIT, 10: 2zl coins loaded at reset/refill.
- STOCK1_INIT, 10: 1zl coins loaded at reset/refill.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. 0 = reset.
- change_valid  in  1  one-cycle request strobe; latches change_amount.
- change_amount  in  8  change to pay in zl, unsigned.
- refill  in  1  reloads all stocks to their *_INIT values.
- Money_out  out  3  one-hot coin being ejected; 000 = none.
- busy  out  1  high from the cycle after an accepted request until the cycle done is asserted (inclusive).
- done  out  1  one-cycle pulse when the transaction ends.
- short  out  1  set with done if the payout was incomplete; held until the next accepted request.
- shortfall  out  8  unpaid zl; valid while short=1, else 0.
- stock5, stock2, stock1  out  8 each  current coin counts.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE.
  - Money_out=000, busy=0, done=0, short=0, shortfall=0.
  - Internal remaining=0.
  - stock5/2/1 = STOCK5_INIT/STOCK2_INIT/STOCK1_INIT.
  - Reset mid-payout aborts immediately. The coin in progress is already counted as paid; no resume.
- All outputs are registered.
- States: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE:
  - change_valid=1 → remaining ← change_amount, short←0, shortfall←0, next state SELECT.
- SELECT (1 cycle), greedy with fallback, checked in this order:
  - remaining≥5 and stock5>0 → coin 5.
  - else remaining≥2 and stock2>0 → coin 2.
  - else remaining≥1 and stock1>0 → coin 1.
  - If a coin is chosen: on the transition to PULSE, Money_out ← its code, remaining −= value, that stock −= 1.
  - remaining=0 → DONE, short=0.
  - remaining>0 and no coin fits → DONE, short←1, shortfall←remaining.
  - Greedy is the decided algorithm. Cases solvable only non-greedily (e.g. 6zl with 1zl stock empty) are reported short; this is not a bug.
- PULSE: Money_out held for exactly PULSE_CYCLES cycles, then → GAP with Money_out←000.
- GAP: GAP_CYCLES cycles of 000, then → SELECT.
- DONE: done=1 for one cycle, busy=1 in that cycle, then → IDLE, busy←0.
- Latency:
  - change_valid sampled at edge N → SELECT in cycle N+1 → first Money_out nonzero in cycle N+2.
  - Each coin costs 1+PULSE_CYCLES+GAP_CYCLES cycles.
  - Zero amount: done asserted in cycle N+2, no coins, short=0.
- change_valid while not in IDLE is ignored; no queueing, no effect on remaining.
- refill:
  - Honoured only in IDLE; ignored in any other state.
  - refill and change_valid in the same IDLE cycle: both take effect, and SELECT sees the reloaded stock.
- Money_out is never more than one-hot, and is 000 in IDLE, SELECT, GAP and DONE.
- Stocks never wrap below 0; a denomination with stock 0 is never selected.

Test Plan:
- Full stock, change_amount=8 → Money_out sequence 100, 010, 001, each 4 cycles wide with 2-cycle gaps; done then; short=0; stock5/2/1 = 9/9/9.
- change_amount=0 → done 2 cycles after change_valid; Money_out stays 000; busy high exactly 1 cycle; stocks unchanged.
- STOCK5_INIT=0, amount=7 → 010, 010, 010, 001; short=0; stock2=7, stock1=9.
- STOCK1_INIT=0, amount=6 → 100 only, then done with short=1, shortfall=1; stock5=9, stock2=10.
- Amount=12, second change_valid (amount=3) mid-payout → ignored; exactly 5, 5, 2 paid. Then refill in IDLE → all stocks=10.
- Reset driven low during the second coin's PULSE → Money_out=000, busy=0 asynchronously; stocks return to INIT values; the next request behaves as from power-up.
